pipe_scheduler: RTL and testbench

- Sequences obstacle spawning for the flappy-bird game.
- Owns a bank of NUM_PIPES pipe slots and tracks which slots are occupied.
- Every SPAWN_PERIOD cycles it picks the next free slot round-robin, issues a one-cycle spawn strobe to that pipe instance, and supplies a pseudo-random gap height.
- Sits between game control (start/die/clear) and the pipe generate array; it replaces the free-running one-hot spawn rotator.

---
 rtl/pipe_scheduler.sv | 179 +++++++++++++++++
 tb/tb_pipe_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scheduler.sv
// Round-robin obstacle spawner for the flappy-bird pipe bank: every SPAWN_PERIOD
// cycles it picks the next free slot, strobes it once and supplies a random gap height.
module pipe_scheduler #(
  parameter int          NUM_PIPES      = 10,
  parameter int          SPAWN_PERIOD   = 50000000,
  parameter int          GAP_MIN        = 60,
  parameter int          GAP_RANGE_LOG2 = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 clear,
  input  logic [NUM_PIPES-1:0] retire,
  output logic [NUM_PIPES-1:0] spawn,
  output logic [8:0]           gap_y,
  output logic [NUM_PIPES-1:0] occupied,
  output logic [7:0]           spawn_total,
  output logic [3:0]           drop_count,
  output logic [2:0]           state_dbg
);

  localparam int IW = (NUM_PIPES > 2) ? $clog2(NUM_PIPES) : 1;
  localparam int TW = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [IW-1:0]        LAST_IDX  = IW'(NUM_PIPES - 1);
  localparam logic [TW-1:0]        LAST_TICK = TW'(SPAWN_PERIOD - 1);
  localparam logic [8:0]           GAP_BASE  = 9'(GAP_MIN);
  localparam logic [NUM_PIPES-1:0] SLOT_ONE  = {{(NUM_PIPES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SEARCH = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [TW-1:0]         timer_r, timer_s, timer_inc_s;
  logic [IW-1:0]         scan_r, scan_s;
  logic [IW-1:0]         scan_cnt_r, scan_cnt_s;
  logic [IW-1:0]         ptr_r, ptr_s;
  logic [NUM_PIPES-1:0]  occ_r, occ_s;
  logic [NUM_PIPES-1:0]  spawn_r, spawn_s;
  logic [8:0]            gap_r, gap_s;
  logic [7:0]            total_r, total_s;
  logic [3:0]            drop_r, drop_s;
  logic [15:0]           lfsr_r, lfsr_s;

  // Fibonacci step with taps 16,14,13,11; the zero guard keeps the sequence alive
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return (n == 16'h0000) ? LFSR_SEED : n;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? {IW{1'b0}} : i + IW'(1);
  endfunction

  // Next-state and datapath: clear beats halt beats the normal sequence
  always_comb begin
    state_s     = state_r;
    timer_inc_s = (timer_r == LAST_TICK) ? {TW{1'b0}} : timer_r + TW'(1);
    timer_s     = timer_r;
    scan_s      = scan_r;
    scan_cnt_s  = scan_cnt_r;
    ptr_s       = ptr_r;
    occ_s       = occ_r & ~retire;
    spawn_s     = {NUM_PIPES{1'b0}};
    gap_s       = gap_r;
    total_s     = total_r;
    drop_s      = drop_r;
    lfsr_s      = lfsr_step(lfsr_r);

    if (clear) begin
      state_s    = ST_IDLE;
      timer_s    = {TW{1'b0}};
      scan_s     = {IW{1'b0}};
      scan_cnt_s = {IW{1'b0}};
      ptr_s      = {IW{1'b0}};
      occ_s      = {NUM_PIPES{1'b0}};
      total_s    = 8'd0;
      drop_s     = 4'd0;
    end else if (halt) begin
      state_s = ST_HALT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timer_s = {TW{1'b0}};
          if (start) begin
            state_s    = ST_SEARCH;
            scan_s     = ptr_r;
            scan_cnt_s = {IW{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          timer_s = timer_inc_s;
          if (timer_r == LAST_TICK) begin
            state_s    = ST_SEARCH;
            scan_s     = ptr_r;
            scan_cnt_s = {IW{1'b0}};
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_SEARCH: begin
          timer_s = timer_inc_s;
          if (!occ_r[scan_r]) begin
            // Commit on ISSUE entry so the strobe, gap and occupancy appear together
            state_s        = ST_ISSUE;
            spawn_s        = SLOT_ONE << scan_r;
            gap_s          = GAP_BASE + 9'(lfsr_r[GAP_RANGE_LOG2-1:0]);
            occ_s[scan_r]  = 1'b1;
            total_s        = (total_r == 8'hFF) ? total_r : total_r + 8'd1;
            ptr_s          = wrap_inc(scan_r);
          end else if (scan_cnt_r == LAST_IDX) begin
            state_s = ST_RUN;
            drop_s  = (drop_r == 4'hF) ? drop_r : drop_r + 4'd1;
          end else begin
            scan_s     = wrap_inc(scan_r);
            scan_cnt_s = scan_cnt_r + IW'(1);
          end
        end
        ST_ISSUE: begin
          timer_s = timer_inc_s;
          state_s = ST_RUN;
        end
        ST_HALT: begin
          state_s = ST_HALT;
        end
        default: begin
          state_s = ST_IDLE;
          timer_s = {TW{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      timer_r    <= {TW{1'b0}};
      scan_r     <= {IW{1'b0}};
      scan_cnt_r <= {IW{1'b0}};
      ptr_r      <= {IW{1'b0}};
      occ_r      <= {NUM_PIPES{1'b0}};
      spawn_r    <= {NUM_PIPES{1'b0}};
      gap_r      <= GAP_BASE;
      total_r    <= 8'd0;
      drop_r     <= 4'd0;
      lfsr_r     <= LFSR_SEED;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      scan_r     <= scan_s;
      scan_cnt_r <= scan_cnt_s;
      ptr_r      <= ptr_s;
      occ_r      <= occ_s;
      spawn_r    <= spawn_s;
      gap_r      <= gap_s;
      total_r    <= total_s;
      drop_r     <= drop_s;
      lfsr_r     <= lfsr_s;
    end
  end

  assign spawn       = spawn_r;
  assign gap_y       = gap_r;
  assign occupied    = occ_r;
  assign spawn_total = total_r;
  assign drop_count  = drop_r;
  assign state_dbg   = state_r;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler: directed test-plan scenarios plus random
// retire traffic checked against an attempt-level reference model.
module tb_pipe_scheduler;
  localparam int N    = 4;
  localparam int P    = 8;
  localparam int GMIN = 60;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, halt = 1'b0, clear = 1'b0;
  logic [N-1:0] retire = '0;
  logic [N-1:0] spawn, occupied;
  logic [8:0]   gap_y;
  logic [7:0]   spawn_total;
  logic [3:0]   drop_count;
  logic [2:0]   state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model: attempt-level view of the scheduler
  logic [N-1:0] m_occ, m_spawn;
  logic [8:0]   m_gap;
  logic [15:0]  m_lfsr;
  int m_ptr, m_total, m_drop, m_mode, m_age, m_scan;
  logic [8:0] gaps[$];

  pipe_scheduler #(.NUM_PIPES(N), .SPAWN_PERIOD(P), .GAP_MIN(GMIN),
                   .GAP_RANGE_LOG2(4), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt), .clear(clear),
    .retire(retire), .spawn(spawn), .gap_y(gap_y), .occupied(occupied),
    .spawn_total(spawn_total), .drop_count(drop_count), .state_dbg(state_dbg));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_occ = '0; m_spawn = '0; m_gap = 9'(GMIN); m_lfsr = SEED;
    m_ptr = 0; m_total = 0; m_drop = 0; m_mode = 0; m_age = 0; m_scan = -1;
  endtask

  // m_mode: 0 waiting for start, 1 spawning, 2 frozen; m_scan: -1 none, 0..N-1 probe k, N strobe cycle
  task automatic model_edge(input logic st, input logic h, input logic c, input logic [N-1:0] ret);
    logic [15:0] l0;
    logic [N-1:0] occ_prev;
    int s;
    l0 = m_lfsr;
    occ_prev = m_occ;
    m_lfsr = lfsr_next(m_lfsr);
    m_spawn = '0;
    if (c) begin
      m_occ = '0; m_ptr = 0; m_total = 0; m_drop = 0; m_mode = 0; m_age = 0; m_scan = -1;
    end else begin
      m_occ = m_occ & ~ret;
      if (h) m_mode = 2;
      else if (m_mode == 0) begin
        if (st) begin m_mode = 1; m_scan = 0; end
      end else if (m_mode == 1) begin
        if (m_scan < 0) begin
          if (m_age == P - 1) m_scan = 0;
        end else if (m_scan == N) m_scan = -1;
        else begin
          s = (m_ptr + m_scan) % N;
          if (!occ_prev[s]) begin
            m_spawn[s] = 1'b1;
            m_gap = 9'(GMIN + int'(l0[3:0]));
            m_occ[s] = 1'b1;
            if (m_total < 255) m_total++;
            m_ptr = (s + 1) % N;
            m_scan = N;
          end else if (m_scan == N - 1) begin
            if (m_drop < 15) m_drop++;
            m_scan = -1;
          end else m_scan++;
        end
        m_age = (m_age == P - 1) ? 0 : m_age + 1;
      end
    end
  endtask

  task automatic step(input logic st, input logic h, input logic c, input logic [N-1:0] ret);
    start = st; halt = h; clear = c; retire = ret;
    @(posedge clk);
    #1;
    model_edge(st, h, c, ret);
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (spawn !== 4'b0000) begin fails++; $display("FAIL reset_spawn got=%b want=0000", spawn); end
    tests++; if (gap_y !== 9'd60) begin fails++; $display("FAIL reset_gap got=%0d want=60", gap_y); end
    tests++; if (occupied !== 4'b0000) begin fails++; $display("FAIL reset_occ got=%b want=0000", occupied); end
    tests++; if (spawn_total !== 8'd0 || drop_count !== 4'd0) begin fails++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", spawn_total, drop_count); end
    tests++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    logic [N-1:0] want;
    for (int k = 0; k < 26; k++) begin
      step((k == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, 4'b0000);
      want = (cyc == 2) ? 4'b0001 : (cyc == 10) ? 4'b0010 : (cyc == 18) ? 4'b0100 :
             (cyc == 26) ? 4'b1000 : 4'b0000;
      tests++; if (spawn !== want) begin fails++; $display("FAIL fill_spawn cyc=%0d got=%b want=%b", cyc, spawn, want); end
      tests++; if (spawn !== m_spawn || gap_y !== m_gap) begin fails++;
        $display("FAIL fill_model cyc=%0d got=%b/%0d want=%b/%0d", cyc, spawn, gap_y, m_spawn, m_gap); end
      if (spawn !== 4'b0000) begin
        gaps.push_back(gap_y);
        tests++; if (gap_y < 9'd60 || gap_y > 9'd75) begin fails++; $display("FAIL fill_gap_range got=%0d want=60..75", gap_y); end
      end
    end
    tests++; if (occupied !== 4'b1111) begin fails++; $display("FAIL fill_occ got=%b want=1111", occupied); end
    tests++; if (spawn_total !== 8'd4) begin fails++; $display("FAIL fill_total got=%0d want=4", spawn_total); end
  endtask

  task automatic test_drop();
    while (cyc < 38) begin
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      tests++; if (spawn !== 4'b0000) begin fails++; $display("FAIL drop_spawn cyc=%0d got=%b want=0000", cyc, spawn); end
      tests++; if (drop_count !== ((cyc >= 37) ? 4'd1 : 4'd0)) begin fails++;
        $display("FAIL drop_count cyc=%0d got=%0d want=%0d", cyc, drop_count, (cyc >= 37) ? 1 : 0); end
    end
    tests++; if (occupied !== 4'b1111) begin fails++; $display("FAIL drop_occ got=%b want=1111", occupied); end
  endtask

  task automatic test_retire();
    logic [N-1:0] want_sp, want_occ;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0, (k == 0) ? 4'b0100 : 4'b0000);
      want_sp  = (cyc == 44) ? 4'b0100 : 4'b0000;
      want_occ = (cyc < 44) ? 4'b1011 : 4'b1111;
      tests++; if (spawn !== want_sp) begin fails++; $display("FAIL retire_spawn cyc=%0d got=%b want=%b", cyc, spawn, want_sp); end
      tests++; if (occupied !== want_occ) begin fails++; $display("FAIL retire_occ cyc=%0d got=%b want=%b", cyc, occupied, want_occ); end
      if (spawn !== 4'b0000) gaps.push_back(gap_y);
    end
    tests++; if (spawn_total !== 8'd5 || drop_count !== 4'd1) begin fails++;
      $display("FAIL retire_counters got=%0d/%0d want=5/1", spawn_total, drop_count); end
  endtask

  task automatic test_halt();
    logic [N-1:0] want_occ;
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 1'b1, 1'b0, (k == 50) ? 4'b0001 : 4'b0000);
      want_occ = (k >= 50) ? 4'b1110 : 4'b1111;
      tests++; if (spawn !== 4'b0000 || state_dbg !== 3'd4) begin fails++;
        $display("FAIL halt_hold k=%0d got=%b/%0d want=0000/4", k, spawn, state_dbg); end
      tests++; if (occupied !== want_occ) begin fails++; $display("FAIL halt_occ k=%0d got=%b want=%b", k, occupied, want_occ); end
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      tests++; if (spawn !== 4'b0000 || state_dbg !== 3'd4) begin fails++;
        $display("FAIL halt_release k=%0d got=%b/%0d want=0000/4", k, spawn, state_dbg); end
    end
    tests++; if (spawn_total !== 8'd5 || drop_count !== 4'd1) begin fails++;
      $display("FAIL halt_counters got=%0d/%0d want=5/1", spawn_total, drop_count); end
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    tests++; if (state_dbg !== 3'd0 || occupied !== 4'b0000) begin fails++;
      $display("FAIL clear_state got=%0d/%b want=0/0000", state_dbg, occupied); end
    tests++; if (spawn_total !== 8'd0 || drop_count !== 4'd0 || spawn !== 4'b0000) begin fails++;
      $display("FAIL clear_counters got=%0d/%0d/%b want=0/0/0000", spawn_total, drop_count, spawn); end
  endtask

  task automatic test_random();
    logic [N-1:0] ret;
    bit differ;
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 400; k++) begin
      ret = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      step(1'b0, 1'b0, 1'b0, ret);
      tests++; if (spawn !== m_spawn || gap_y !== m_gap) begin fails++;
        $display("FAIL rand_spawn cyc=%0d got=%b/%0d want=%b/%0d", cyc, spawn, gap_y, m_spawn, m_gap); end
      tests++; if (occupied !== m_occ) begin fails++; $display("FAIL rand_occ cyc=%0d got=%b want=%b", cyc, occupied, m_occ); end
      tests++; if (spawn_total !== 8'(m_total) || drop_count !== 4'(m_drop)) begin fails++;
        $display("FAIL rand_counters cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, spawn_total, drop_count, m_total, m_drop); end
      if (spawn !== 4'b0000) begin
        gaps.push_back(gap_y);
        tests++; if (gap_y < 9'd60 || gap_y > 9'd75) begin fails++; $display("FAIL rand_gap_range got=%0d want=60..75", gap_y); end
      end
    end
    tests++;
    if (gaps.size() < 16) begin
      fails++; $display("FAIL gap_count got=%0d want>=16", gaps.size());
    end else begin
      differ = 1'b0;
      for (int i = 1; i < 16; i++) if (gaps[i] !== gaps[0]) differ = 1'b1;
      if (!differ) begin fails++; $display("FAIL gap_constant got=%0d repeated want=varying", gaps[0]); end
    end
  endtask

  task automatic test_reset_issue();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'b1111);
      if (spawn !== 4'b0000) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL rst_issue_wait got=no_spawn want=spawn within 30 cycles");
    end else begin
      reset_n = 1'b0;
      #1;
      if (spawn !== 4'b0000 || state_dbg !== 3'd0 || occupied !== 4'b0000) begin fails++;
        $display("FAIL rst_issue got=%b/%0d/%b want=0000/0/0000", spawn, state_dbg, occupied); end
      tests++; if (spawn_total !== 8'd0 || gap_y !== 9'd60) begin fails++;
        $display("FAIL rst_issue_regs got=%0d/%0d want=0/60", spawn_total, gap_y); end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drop();
    test_retire();
    test_halt();
    test_random();
    test_reset_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
